// File: rtl/tile_launch_scheduler.sv
// tile_launch_scheduler
// Issues one start handshake per tile of a job into the MAC -> bias -> FIFO ->
// sigmoid datapath, caps tiles in flight so the bias-to-sigmoid FIFO cannot
// overrun, retires a tile after TOKENS_PER_TILE sigmoid outputs, and pulses
// done_pulse once the whole job has drained.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a job command (cmd_ready high)
// ISSUE   | offering a tile start while under the outstanding cap
// GAP     | enforced idle spacing after an accepted start
// DRAIN   | all starts issued, waiting for in-flight tiles to retire
// DONE    | one-cycle completion, done_pulse high
module tile_launch_scheduler #(
    parameter int CNT_W           = 16,
    parameter int TOKENS_PER_TILE = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int GAP_CYCLES      = 0,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_num_tiles,
    output logic             start_valid,
    input  logic             start_ready,
    input  logic             out_fire,
    output logic             busy,
    output logic             done_pulse,
    output logic [OUT_W-1:0] outstanding,
    output logic [CNT_W-1:0] tiles_issued,
    output logic             err_underflow
);

    localparam int TOK_W = (TOKENS_PER_TILE > 1) ? $clog2(TOKENS_PER_TILE) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   tiles_issued_q;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [TOK_W-1:0]   tok_q;
    logic [GAP_W-1:0]   gap_q;
    logic               err_q;
    logic               done_q;

    logic cmd_fire;
    logic start_fire;
    logic tok_fire;
    logic retire;
    logic last_start;

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign start_fire = start_valid && start_ready;
    // Tokens arriving with nothing in flight are stray and must not move the counters.
    assign tok_fire   = out_fire && (outstanding_q != '0);
    assign retire     = tok_fire && (tok_q == TOK_W'(TOKENS_PER_TILE - 1));
    assign last_start = ((tiles_issued_q + CNT_W'(1)) == num_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_num_tiles == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (start_fire) begin
                    if (last_start) begin
                        state_d = S_DRAIN;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_GAP: begin
                // <= 1 rather than == 1 so a zero count can never wedge the FSM.
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if ((outstanding_q == '0) && (tok_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; depend only on registers, never on inputs.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        start_valid = (state_q == S_ISSUE) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    end

    // In-flight tile count: a start and a retire in the same cycle cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({start_fire, retire})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Job, token, gap and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q          <= '0;
            tiles_issued_q <= '0;
            outstanding_q  <= '0;
            tok_q          <= '0;
            gap_q          <= '0;
            err_q          <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            if (cmd_fire) begin
                num_q          <= cmd_num_tiles;
                tiles_issued_q <= '0;
            end else if (start_fire) begin
                tiles_issued_q <= tiles_issued_q + CNT_W'(1);
            end

            outstanding_q <= outstanding_d;

            if (tok_fire) begin
                tok_q <= retire ? '0 : tok_q + TOK_W'(1);
            end

            if (start_fire) begin
                gap_q <= GAP_W'(GAP_CYCLES);
            end else if (state_q == S_GAP) begin
                gap_q <= gap_q - GAP_W'(1);
            end

            if (out_fire && (outstanding_q == '0)) begin
                err_q <= 1'b1;
            end

            done_q <= (state_d == S_DONE);
        end
    end

    assign outstanding   = outstanding_q;
    assign tiles_issued  = tiles_issued_q;
    assign err_underflow = err_q;
    assign done_pulse    = done_q;

endmodule

// File: tb/tb_tile_launch_scheduler.sv
// Directed bench for tile_launch_scheduler with default parameters
// (64 tokens per tile, at most 2 tiles in flight, no gap).
module tb_tile_launch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_num_tiles;
    logic        start_valid;
    logic        start_ready;
    logic        out_fire;
    logic        busy;
    logic        done_pulse;
    logic [1:0]  outstanding;
    logic [15:0] tiles_issued;
    logic        err_underflow;

    int tests = 0;
    int fails = 0;

    tile_launch_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_num_tiles (cmd_num_tiles),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .out_fire      (out_fire),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .outstanding   (outstanding),
        .tiles_issued  (tiles_issued),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // Inputs held for rep cycles, then outputs checked after the last edge.
    typedef struct {
        int rep;
        int cv;
        int num;
        int sr;
        int fire;
        int busy;
        int sv;
        int outs;
        int ti;
        int done;
        int cr;
        int err;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int rep, input int cv, input int num, input int sr, input int fire,
                       input int b, input int sv, input int o, input int ti, input int d,
                       input int cr, input int e);
        vec_t v;
        v.rep = rep; v.cv = cv; v.num = num; v.sr = sr; v.fire = fire;
        v.busy = b; v.sv = sv; v.outs = o; v.ti = ti; v.done = d; v.cr = cr; v.err = e;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int b, input int sv, input int o,
                             input int ti, input int d, input int cr);
        chk({tag, " busy"},         int'(busy),         b);
        chk({tag, " start_valid"},  int'(start_valid),  sv);
        chk({tag, " outstanding"},  int'(outstanding),  o);
        chk({tag, " tiles_issued"}, int'(tiles_issued), ti);
        chk({tag, " done_pulse"},   int'(done_pulse),   d);
        chk({tag, " cmd_ready"},    int'(cmd_ready),    cr);
    endtask

    task automatic cyc(input int cv, input int num, input int sr, input int fire);
        cmd_valid     = (cv != 0);
        cmd_num_tiles = 16'(num);
        start_ready   = (sr != 0);
        out_fire      = (fire != 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hs;
        int  viol;
        bit  pend;
        bit  seen;
        int  sr_r;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_num_tiles = '0; start_ready = 1'b0; out_fire = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0, 0, 1);
        chk("reset err_underflow", int'(err_underflow), 0);
        rst = 1'b0;

        // Single tile.
        add(1,  1, 1, 0, 0,  1, 1, 0, 1'b0, 0, 0, 0);
        add(1,  0, 0, 1, 0,  1, 0, 1, 1, 0, 0, 0);
        add(63, 0, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0);
        add(1,  0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0);
        add(1,  0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0);
        add(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        // Credit limit: five tiles, two in flight.
        add(1,  1, 5, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add(1,  0, 0, 1, 0,  1, 1, 1, 1, 0, 0, 0);
        add(1,  0, 0, 1, 0,  1, 0, 2, 2, 0, 0, 0);
        add(5,  0, 0, 1, 0,  1, 0, 2, 2, 0, 0, 0);
        add(64, 0, 0, 1, 1,  1, 1, 1, 2, 0, 0, 0);
        add(1,  0, 0, 1, 0,  1, 0, 2, 3, 0, 0, 0);
        add(64, 0, 0, 1, 1,  1, 1, 1, 3, 0, 0, 0);
        add(1,  0, 0, 1, 0,  1, 0, 2, 4, 0, 0, 0);
        add(64, 0, 0, 1, 1,  1, 1, 1, 4, 0, 0, 0);
        add(1,  0, 0, 1, 0,  1, 0, 2, 5, 0, 0, 0);
        add(127,0, 0, 1, 1,  1, 0, 1, 5, 0, 0, 0);
        add(1,  0, 0, 1, 1,  1, 0, 0, 5, 0, 0, 0);
        add(1,  0, 0, 0, 0,  1, 0, 0, 5, 1, 0, 0);
        add(1,  0, 0, 0, 0,  0, 0, 0, 5, 0, 1, 0);
        // Zero-tile job, then a stray token in IDLE.
        add(1,  1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0);
        add(1,  0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1);
        add(3,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);

        foreach (vt[i]) begin
            for (int r = 0; r < vt[i].rep; r++) cyc(vt[i].cv, vt[i].num, vt[i].sr, vt[i].fire);
            chk_state($sformatf("vec%0d", i), vt[i].busy, vt[i].sv, vt[i].outs,
                      vt[i].ti, vt[i].done, vt[i].cr);
            chk($sformatf("vec%0d err_underflow", i), int'(err_underflow), vt[i].err);
        end

        // Start handshake and tile retire on the same edge.
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("sim pre outstanding", int'(outstanding), 2);
        repeat (64) cyc(0, 0, 0, 1);
        chk("sim first retire outstanding", int'(outstanding), 1);
        chk("sim first retire start_valid", int'(start_valid), 1);
        repeat (63) cyc(0, 0, 0, 1);
        chk("sim held start_valid", int'(start_valid), 1);
        chk("sim held tiles_issued", int'(tiles_issued), 2);
        cyc(0, 0, 1, 1);
        chk("sim edge outstanding", int'(outstanding), 1);
        chk("sim edge tiles_issued", int'(tiles_issued), 3);
        chk("sim edge start_valid", int'(start_valid), 0);
        repeat (63) cyc(0, 0, 0, 1);
        chk("sim drain outstanding", int'(outstanding), 1);
        cyc(0, 0, 0, 1);
        chk("sim last retire outstanding", int'(outstanding), 0);
        chk("sim last retire done", int'(done_pulse), 0);
        cyc(0, 0, 0, 0);
        chk("sim done_pulse", int'(done_pulse), 1);
        cyc(0, 0, 0, 0);
        chk("sim back idle", int'(cmd_ready), 1);

        // Random start backpressure, six tiles.
        cyc(1, 6, 0, 0);
        hs = 0; viol = 0; pend = 1'b0; seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            if (pend && !start_valid) viol++;
            sr_r = ($urandom_range(0, 99) < 30) ? 1 : 0;
            if (start_valid && sr_r != 0) hs++;
            pend = start_valid && (sr_r == 0);
            cyc(0, 0, sr_r, (outstanding != 2'd0) ? 1 : 0);
            if (done_pulse) seen = 1'b1;
        end
        chk("bp done seen", int'(seen), 1);
        chk("bp handshakes", hs, 6);
        chk("bp valid drops", viol, 0);
        chk("bp tiles_issued", int'(tiles_issued), 6);
        cyc(0, 0, 0, 0);

        // Reset in the middle of DRAIN.
        cyc(1, 2, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("rst pre outstanding", int'(outstanding), 2);
        chk("rst pre err_underflow", int'(err_underflow), 1);
        repeat (5) cyc(0, 0, 0, 1);
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk_state("rst mid", 0, 0, 0, 0, 0, 1);
        chk("rst mid err_underflow", int'(err_underflow), 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("post outstanding", int'(outstanding), 1);
        chk("post tiles_issued", int'(tiles_issued), 1);
        repeat (63) cyc(0, 0, 0, 1);
        chk("post token count fresh", int'(outstanding), 1);
        cyc(0, 0, 0, 1);
        chk("post retire", int'(outstanding), 0);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            cyc(0, 0, 0, 0);
            if (done_pulse) seen = 1'b1;
        end
        chk("post done seen", int'(seen), 1);
        cyc(0, 0, 0, 0);
        chk("post idle", int'(cmd_ready), 1);
        chk("post err_underflow", int'(err_underflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
